// File: rtl/sample_uart_logger_pkg.sv
// Shared constants, FSM state type and checksum helper for the sample UART logger.
package sample_uart_logger_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    localparam logic [1:0] BYTE_HDR  = 2'd0;
    localparam logic [1:0] BYTE_DATA = 2'd1;
    localparam logic [1:0] BYTE_CSUM = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    // Checksum byte closing every packet: header XOR sample.
    function automatic logic [7:0] packet_csum(input logic [7:0] sample);
        return HEADER_BYTE ^ sample;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Register-based sample FIFO with occupancy count and full/empty flags.
// Pushes while full and pops while empty are ignored.
module sample_fifo
    import sample_uart_logger_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    wr_data,
    input  logic                          pop,
    output logic [7:0]                    rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_uart_logger.sv
// Buffers converter samples and streams each as a 3-byte 8N1 UART packet:
// HEADER, sample, HEADER^sample. Never back-pressures; drops set a sticky flag.
module sample_uart_logger
    import sample_uart_logger_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    sample_data,
    input  logic                          sample_valid,
    input  logic                          clear_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int               BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [1:0]    byte_idx, byte_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    sample_q, sample_n;
    logic          tx_n;
    logic          baud_last;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic          drop;

    assign fifo_push = sample_valid && !fifo_full;
    assign drop      = sample_valid && fifo_full;
    assign baud_last = (baud_cnt == BAUD_LAST);

    sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (sample_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state, counters and the registered value tx takes in the next state.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        byte_n   = byte_idx;
        shreg_n  = shreg;
        sample_n = sample_q;
        fifo_pop = 1'b0;
        tx_n     = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                fifo_pop = 1'b1;
                sample_n = fifo_rd_data;
                shreg_n  = HEADER_BYTE;
                byte_n   = BYTE_HDR;
                baud_n   = '0;
                state_n  = START;
                tx_n     = 1'b0;
            end
            START: begin
                tx_n = 1'b0;
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                    tx_n    = shreg[0];
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            DATA: begin
                tx_n = shreg[0];
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        tx_n    = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_last) begin
                    baud_n = '0;
                    case (byte_idx)
                        BYTE_HDR: begin
                            byte_n  = BYTE_DATA;
                            shreg_n = sample_q;
                            state_n = START;
                            tx_n    = 1'b0;
                        end
                        BYTE_DATA: begin
                            byte_n  = BYTE_CSUM;
                            shreg_n = packet_csum(sample_q);
                            state_n = START;
                            tx_n    = 1'b0;
                        end
                        default: begin
                            state_n = fifo_empty ? IDLE : LOAD;
                        end
                    endcase
                end else begin
                    baud_n = baud_cnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Control state and registered outputs; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= BYTE_HDR;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            byte_idx <= byte_n;
            tx       <= tx_n;
            busy     <= (state_n != IDLE);
        end
    end

    // Byte shifter and latched sample: datapath only, no reset.
    always_ff @(posedge clk) begin
        shreg    <= shreg_n;
        sample_q <= sample_n;
    end

    // Sticky overflow: a drop in the same cycle as clear_ovf keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sample_uart_logger.sv
// Testbench for sample_uart_logger: directed scenarios plus randomized traffic,
// checked cycle by cycle against a service-time model and a UART decoder.
module tb_sample_uart_logger;

    localparam int         CPB   = 4;
    localparam int         DEPTH = 8;
    localparam int         PKT   = 30 * CPB;
    localparam logic [7:0] HDR   = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sample_data = 8'h00;
    logic       sample_valid = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;
    logic       overflow;

    sample_uart_logger #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .clear_ovf    (clear_ovf),
        .tx           (tx),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the serializer is a single server. It inspects the
    // queue at a "look" edge; if something is waiting it pops one edge later,
    // the start bit follows that pop, and it looks again a packet time later.
    longint     cyc = 0;
    int         occ = 0;
    int         occ_pre;
    bit         m_busy = 0, m_ovf = 0, m_load = 0, m_popped = 0;
    longint     look_at = 0, pop_at = -1;
    logic [7:0] exp_q[$];

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            occ = 0; m_busy = 0; m_ovf = 0; m_load = 0; m_popped = 0;
            look_at = 0; pop_at = -1;
            exp_q.delete();
        end else begin
            cyc++;
            occ_pre  = occ;
            m_popped = (cyc == pop_at);
            m_load   = 0;
            if (sample_valid && occ_pre < DEPTH) begin
                occ++;
                exp_q.push_back(HDR);
                exp_q.push_back(sample_data);
                exp_q.push_back(HDR ^ sample_data);
            end
            if (sample_valid && occ_pre >= DEPTH) m_ovf = 1;
            else if (clear_ovf)                    m_ovf = 0;
            if (m_popped) occ--;
            if (cyc >= look_at) begin
                if (occ_pre > 0) begin
                    m_busy = 1; m_load = 1;
                    pop_at = cyc + 1;
                    look_at = cyc + 1 + PKT;
                end else begin
                    m_busy = 0;
                    look_at = cyc + 1;
                end
            end
        end
    end

    // Per-cycle comparison of registered outputs against the model.
    initial forever begin
        @(negedge clk);
        chk("fifo_count", 32'(fifo_count), 32'(occ));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (!m_busy || m_load) chk("tx_idle_high", 32'(tx), 32'd1);
        if (m_popped)          chk("tx_start_low", 32'(tx), 32'd0);
    end

    // UART receiver: samples 1.5 clocks into each bit, checks framing and
    // compares every byte against the expected stream.
    bit         dec_on = 0;
    int         dec_cnt = 0;
    int         dec_k;
    int         n_bytes = 0;
    logic [7:0] dec_byte;
    logic [7:0] exp_b;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            dec_on = 0;
        end else if (!dec_on) begin
            if (tx === 1'b0) begin
                dec_on = 1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt % CPB == 1) begin
                dec_k = dec_cnt / CPB;
                if (dec_k == 0) begin
                    chk("start_bit", 32'(tx), 32'd0);
                end else if (dec_k <= 8) begin
                    dec_byte[dec_k-1] = tx;
                end else begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    chk("rx_byte", 32'(dec_byte), 32'(exp_b));
                    n_bytes++;
                    dec_on = 0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!m_busy && occ == 0 && !dec_on) break;
            @(negedge clk);
        end
        chk("drain_in_time", 32'(i < budget), 32'd1);
    endtask

    int nb0;
    int wait_n;
    int burst;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);

        // Single sample: start bit two edges after strobe, 120-cycle packet
        push(8'h96);
        @(negedge clk);
        chk("t1_load_tx", 32'(tx), 32'd1);
        @(negedge clk);
        chk("t1_start_tx", 32'(tx), 32'd0);
        chk("t1_start_busy", 32'(busy), 32'd1);
        repeat (119) @(negedge clk);
        chk("t1_busy_late", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_busy_end", 32'(busy), 32'd0);
        wait_idle(400);

        // Two samples three cycles apart
        push(8'h96);
        repeat (2) @(negedge clk);
        push(8'h2D);
        wait_idle(600);

        // Ten consecutive strobes: ninth fills the FIFO, tenth is dropped
        for (int i = 1; i <= 10; i++) begin
            push(8'(i));
            if (i == 9) chk("t3_peak_count", 32'(fifo_count), 32'd8);
        end
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_count_full", 32'(fifo_count), 32'd8);
        wait_idle(2000);
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);

        // Reset in the middle of the second byte's data bits
        push(8'h11);
        push(8'h22);
        repeat (55) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_tx", 32'(tx), 32'd1);
        chk("t4_rst_count", 32'(fifo_count), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nb0 = n_bytes;
        push(8'h55);
        wait_idle(400);
        chk("t4_bytes_after_rst", 32'(n_bytes - nb0), 32'd3);

        // Push and pop on the same edge with three entries waiting
        push(8'h31);
        repeat (3) @(negedge clk);
        push(8'h32);
        push(8'h33);
        push(8'h34);
        wait_n = 0;
        while (pop_at != cyc + 1 && wait_n < 400) begin
            @(negedge clk);
            wait_n++;
        end
        chk("t5_pop_found", 32'(wait_n < 400), 32'd1);
        chk("t5_count_before", 32'(fifo_count), 32'd3);
        push(8'h35);
        chk("t5_count_after", 32'(fifo_count), 32'd3);
        wait_idle(1000);

        // Randomized traffic with bursts, gaps and clear pulses
        for (int it = 0; it < 25; it++) begin
            burst = $urandom_range(1, 12);
            for (int j = 0; j < burst; j++) begin
                sample_data  = 8'($urandom);
                sample_valid = ($urandom_range(0, 3) != 0);
                clear_ovf    = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
            sample_valid = 1'b0;
            clear_ovf    = 1'b0;
            repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        wait_idle(3000);
        chk("all_bytes_received", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
